// File: rtl/rl_capture_sink.sv
// Debounced capture of a held {address, data} pair into a 16x8 register file.
// Optional XOR checksum of captured bytes enabled by defining RL_CAPTURE_CHECKSUM_EN.
module rl_capture_sink #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       a3_a0,
  input  logic [7:0]       z7_z0,
  input  logic             clr,
  input  logic [3:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             wr_pulse,
  output logic [3:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic [15:0]      valid,
  output logic [CNT_W-1:0] cap_count,
  output logic             overwrite,
  output logic [7:0]       chk
);

  logic [3:0]       r_prev_a;
  logic [7:0]       r_prev_z;
  logic [3:0]       r_cnt;
  logic             r_armed;
  logic [7:0]       r_mem [16];
  logic [7:0]       r_rd_data;
  logic             r_wr_pulse;
  logic [3:0]       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic [15:0]      r_valid;
  logic [CNT_W-1:0] r_cap_count;
  logic             r_overwrite;

  logic             w_changed;
  logic             w_capture;
  logic [15:0]      w_valid_base;
  logic [15:0]      w_valid_nxt;
  logic [CNT_W-1:0] w_count_base;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_overwrite_nxt;

  assign w_changed = {a3_a0, z7_z0} != {r_prev_a, r_prev_z};
  assign w_capture = !w_changed && r_armed && (r_cnt == 4'(STABLE_CYCLES - 1));

  // clr is folded in before the capture so a same-edge capture lands on cleared bookkeeping
  always_comb begin
    w_valid_base    = clr ? '0 : r_valid;
    w_count_base    = clr ? '0 : r_cap_count;
    w_valid_nxt     = w_valid_base;
    w_count_nxt     = w_count_base;
    w_overwrite_nxt = clr ? 1'b0 : r_overwrite;
    if (w_capture) begin
      w_valid_nxt = w_valid_base | (16'h0001 << r_prev_a);
      if (w_count_base != '1) begin
        w_count_nxt = w_count_base + CNT_W'(1);
      end
      if (w_valid_base[r_prev_a] && (r_mem[r_prev_a] != r_prev_z)) begin
        w_overwrite_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_a <= '0;
      r_prev_z <= '0;
      r_cnt    <= '0;
      r_armed  <= 1'b1;
    end else if (w_changed) begin
      r_prev_a <= a3_a0;
      r_prev_z <= z7_z0;
      r_cnt    <= 4'd1;
      r_armed  <= 1'b1;
    end else if (w_capture) begin
      r_cnt    <= '0;
      r_armed  <= 1'b0;
    end else if (r_armed) begin
      r_cnt    <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data   <= '0;
      r_wr_pulse  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_valid     <= '0;
      r_cap_count <= '0;
      r_overwrite <= 1'b0;
    end else begin
      r_rd_data   <= r_mem[rd_addr];
      r_wr_pulse  <= w_capture;
      r_valid     <= w_valid_nxt;
      r_cap_count <= w_count_nxt;
      r_overwrite <= w_overwrite_nxt;
      if (w_capture) begin
        r_mem[r_prev_a] <= r_prev_z;
        r_wr_addr       <= r_prev_a;
        r_wr_data       <= r_prev_z;
      end
    end
  end

`ifdef RL_CAPTURE_CHECKSUM_EN
  logic [7:0] r_chk;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_chk <= '0;
    end else begin
      r_chk <= (clr ? 8'h00 : r_chk) ^ (w_capture ? r_prev_z : 8'h00);
    end
  end

  assign chk = r_chk;
`else
  assign chk = 8'h00;
`endif

  assign rd_data   = r_rd_data;
  assign wr_pulse  = r_wr_pulse;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign valid     = r_valid;
  assign cap_count = r_cap_count;
  assign overwrite = r_overwrite;

endmodule

// File: tb/tb_rl_capture_sink.sv
// Directed bench for rl_capture_sink: table of held pairs plus hand sequences
// for read-before-write, clr interactions, mid-hold reset and count saturation.
module tb_rl_capture_sink;

`ifdef RL_CAPTURE_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  a3_a0 = '0;
  logic [7:0]  z7_z0 = '0;
  logic        clr = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        wr_pulse;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] valid;
  logic [7:0]  cap_count;
  logic        overwrite;
  logic [7:0]  chk;

  int n_cmp = 0;
  int n_bad = 0;

  rl_capture_sink #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .a3_a0(a3_a0), .z7_z0(z7_z0), .clr(clr),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
    .wr_data(wr_data), .valid(valid), .cap_count(cap_count), .overwrite(overwrite),
    .chk(chk)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  z;
    int          hold;
    logic [3:0]  rd;
    int          pulses;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic [15:0] vld;
    logic [7:0]  cnt;
    logic        ovw;
    logic [7:0]  ck;
    logic [7:0]  rdv;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xchk(input logic [7:0] v);
    return CHK_EN ? v : 8'h00;
  endfunction

  initial begin
    int pulses;
    int pulse_edge;

    //         a     z      hold rd    p  wa    wd     valid     cnt    ovw   chk    rd_data
    vecs[0] = '{4'h5, 8'hA7, 10, 4'h0, 1, 4'h5, 8'hA7, 16'h0021, 8'd2, 1'b0, 8'hA7, 8'h00};
    vecs[1] = '{4'h3, 8'h11, 3,  4'h5, 0, 4'h5, 8'hA7, 16'h0021, 8'd2, 1'b0, 8'hA7, 8'hA7};
    vecs[2] = '{4'h3, 8'h22, 4,  4'h3, 1, 4'h3, 8'h22, 16'h0029, 8'd3, 1'b0, 8'h85, 8'h00};
    vecs[3] = '{4'h2, 8'h10, 5,  4'h3, 1, 4'h2, 8'h10, 16'h002D, 8'd4, 1'b0, 8'h95, 8'h22};
    vecs[4] = '{4'h2, 8'h20, 5,  4'h2, 1, 4'h2, 8'h20, 16'h002D, 8'd5, 1'b1, 8'hB5, 8'h20};
    vecs[5] = '{4'h6, 8'h00, 2,  4'h2, 0, 4'h2, 8'h20, 16'h002D, 8'd5, 1'b1, 8'hB5, 8'h20};
    vecs[6] = '{4'h2, 8'h20, 4,  4'h2, 1, 4'h2, 8'h20, 16'h002D, 8'd6, 1'b1, 8'h95, 8'h20};
    vecs[7] = '{4'h9, 8'h44, 4,  4'h9, 1, 4'h9, 8'h44, 16'h022D, 8'd7, 1'b1, 8'hD1, 8'h00};

    tick();
    tick();
    reset = 1'b0;
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_valid", valid, 0);
    check("rst_cap_count", cap_count, 0);
    check("rst_overwrite", overwrite, 0);
    check("rst_chk", chk, 0);

    // held 0/0 after reset is captured on the 4th edge
    pulses = 0;
    pulse_edge = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (wr_pulse) begin
        pulses++;
        pulse_edge = e;
      end
    end
    check("zero_pulses", pulses, 1);
    check("zero_pulse_edge", pulse_edge, 4);
    check("zero_valid", valid, 16'h0001);
    check("zero_cap_count", cap_count, 1);
    check("zero_rd_data", rd_data, 0);

    for (int v = 0; v < 8; v++) begin
      a3_a0 = vecs[v].a;
      z7_z0 = vecs[v].z;
      rd_addr = vecs[v].rd;
      pulses = 0;
      for (int e = 0; e < vecs[v].hold; e++) begin
        tick();
        if (wr_pulse) pulses++;
      end
      check($sformatf("v%0d_pulses", v), pulses, vecs[v].pulses);
      check($sformatf("v%0d_wr_addr", v), wr_addr, vecs[v].wa);
      check($sformatf("v%0d_wr_data", v), wr_data, vecs[v].wd);
      check($sformatf("v%0d_valid", v), valid, vecs[v].vld);
      check($sformatf("v%0d_cap_count", v), cap_count, vecs[v].cnt);
      check($sformatf("v%0d_overwrite", v), overwrite, vecs[v].ovw);
      check($sformatf("v%0d_chk", v), chk, xchk(vecs[v].ck));
      check($sformatf("v%0d_rd_data", v), rd_data, vecs[v].rdv);
    end

    // read-before-write: capture 9/55 over 44 while reading address 9
    a3_a0 = 4'h9;
    z7_z0 = 8'h55;
    rd_addr = 4'h9;
    tick(); tick(); tick();
    check("rbw_pre_rd", rd_data, 8'h44);
    check("rbw_pre_pulse", wr_pulse, 0);
    tick();
    check("rbw_cap_pulse", wr_pulse, 1);
    check("rbw_cap_rd_old", rd_data, 8'h44);
    tick();
    check("rbw_next_rd_new", rd_data, 8'h55);
    check("rbw_pulse_drop", wr_pulse, 0);
    check("rbw_cap_count", cap_count, 8);
    check("rbw_chk", chk, xchk(8'h84));

    // clr on the capture edge of 7/3C
    a3_a0 = 4'h7;
    z7_z0 = 8'h3C;
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrcap_pulse", wr_pulse, 1);
    check("clrcap_valid", valid, 16'h0080);
    check("clrcap_cap_count", cap_count, 1);
    check("clrcap_overwrite", overwrite, 0);
    check("clrcap_chk", chk, xchk(8'h3C));
    check("clrcap_wr_data", wr_data, 8'h3C);

    // plain clr leaves memory and last-capture registers intact
    clr = 1'b1;
    rd_addr = 4'h2;
    tick();
    clr = 1'b0;
    check("clr_valid", valid, 0);
    check("clr_cap_count", cap_count, 0);
    check("clr_overwrite", overwrite, 0);
    check("clr_chk", chk, 0);
    check("clr_mem2", rd_data, 8'h20);
    check("clr_wr_addr", wr_addr, 4'h7);

    // reset at cnt=2 of a hold discards the partial count
    a3_a0 = 4'h4;
    z7_z0 = 8'h77;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_rd_data", rd_data, 0);
    check("mrst_pulse", wr_pulse, 0);
    check("mrst_wr_addr", wr_addr, 0);
    check("mrst_wr_data", wr_data, 0);
    check("mrst_valid", valid, 0);
    check("mrst_cap_count", cap_count, 0);
    check("mrst_overwrite", overwrite, 0);
    check("mrst_chk", chk, 0);
    pulses = 0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (wr_pulse) pulses++;
    end
    check("mrst_no_early_pulse", pulses, 0);
    check("mrst_mem2_cleared", rd_data, 0);
    tick();
    check("mrst_late_pulse", wr_pulse, 1);
    check("mrst_valid_after", valid, 16'h0010);
    check("mrst_cap_count_after", cap_count, 1);

    // saturation: 260 more captures on top of the one above
    for (int i = 0; i < 260; i++) begin
      a3_a0 = 4'(i);
      z7_z0 = 8'(i) ^ 8'h5A;
      tick(); tick(); tick(); tick();
    end
    check("sat_cap_count", cap_count, 8'd255);
    check("sat_valid", valid, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rl_capture_sink.md
Name: rl_capture_sink

Overview:
- Downstream consumer of the address/data stage that drives a 4-bit address and an 8-bit data byte, each held for several clock periods.
- Debounces the pair and captures it exactly once per stable hold into a 16x8 register file indexed by address.
- Keeps per-address valid bits, a capture counter and an overwrite flag.
- Exposes a registered read port for the next stage.

Parameters:
- STABLE_CYCLES, 4: number of consecutive sampled edges with an unchanged {a3_a0,z7_z0} required for capture; legal range 2..15.
- CNT_W, 8: width of the saturating capture counter.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
- a3_a0  in  4  address from the upstream stage.
- z7_z0  in  8  data from the upstream stage.
- clr  in  1  synchronous clear of the bookkeeping (valid, count, overwrite, checksum); does not clear memory.
- rd_addr  in  4  read address.
- rd_data  out  8  registered read data.
- wr_pulse  out  1  one-clock strobe per capture.
- wr_addr  out  4  address of the last capture.
- wr_data  out  8  data of the last capture.
- valid  out  16  bit i set once address i has been captured.
- cap_count  out  CNT_W  number of captures, saturating.
- overwrite  out  1  sticky flag.
- chk  out  8  checksum (see Optional Feature).

Behaviour:
- Reset (reset=1 at an edge) sets:
  - all 16 memory entries to 0;
  - rd_data, wr_addr, wr_data, valid, cap_count, chk to 0;
  - wr_pulse and overwrite to 0;
  - internal prev={0,0}, cnt=0, armed=1.
- Reset asserted mid-hold discards any partial stability count.
- Stability tracker, evaluated every edge when reset=0:
  - If {a3_a0,z7_z0} != prev: prev<=input, cnt<=1, armed<=1.
  - Else if armed and cnt==STABLE_CYCLES-1: capture edge; armed<=0, cnt<=0.
  - Else if armed: cnt<=cnt+1.
  - Else (not armed): hold.
- Net effect: capture occurs on the STABLE_CYCLES-th consecutive edge sampling the same pair. After reset the held 0/0 pair counts from cnt=0, so it is captured on the STABLE_CYCLES-th edge.
- A pair is captured at most once per hold. A new capture requires a change, then a fresh count. Glitches shorter than STABLE_CYCLES edges are never captured.
- On a capture edge:
  - mem[prev_a] <= prev_z; wr_addr/wr_data <= prev pair; wr_pulse<=1 for exactly the next clock cycle, otherwise 0.
  - overwrite <= 1 if valid[prev_a] was already 1 and mem[prev_a] != prev_z. It stays set until reset or clr.
  - valid[prev_a]<=1; cap_count<=cap_count+1, saturating at 2^CNT_W-1.
- Read port:
  - rd_data <= mem[rd_addr] on every edge (1-cycle latency).
  - If the same edge writes the same address, rd_data returns the old value (read-before-write).
- clr=1:
  - clears valid, cap_count, overwrite and chk.
  - Memory, wr_addr, wr_data and the stability tracker are unaffected.
- clr together with a capture on the same edge: the clear applies first, then the capture. Result: valid has only bit prev_a set, cap_count=1, overwrite=0, chk=prev_z (if enabled), memory written.
- reset has priority over clr and capture.

Optional Feature:
- Macro RL_CAPTURE_CHECKSUM_EN.
- Defined: chk <= chk ^ captured data on each capture edge; chk is reset/cleared to 0.
- Undefined: no checksum register; chk is tied to 8'h00. All other behaviour is identical.

Test Plan:
- Reset, hold 0/0 for 6 edges -> wr_pulse once, on the cycle after edge 4; mem[0]=0; valid=16'h0001; cap_count=1.
- Drive a=5,z=8'hA7 held 10 edges -> exactly one wr_pulse; valid[5]=1; then rd_addr=5 -> rd_data=8'hA7 one cycle later.
- Hold a=3,z=8'h11 for only 3 edges, then a=3,z=8'h22 for 4 edges -> single capture of 8'h22; 8'h11 is never written.
- Capture a=2,z=8'h10, then a=2,z=8'h20 -> overwrite=1. Re-capture a=2,z=8'h20 after an intervening change -> overwrite stays 1 and cap_count increments. Then clr -> overwrite=0, valid=0, cap_count=0, and mem[2] still reads 8'h20.
- Assert clr on a capture edge of a=7,z=8'h3C -> valid=16'h0080, cap_count=1; chk=8'h3C with RL_CAPTURE_CHECKSUM_EN, 8'h00 without.
- Rd_addr=9 on the same edge as a capture writing a=9,z=8'h55 over previous 8'h44 -> rd_data=8'h44, then 8'h55 on the next edge. Reset asserted at cnt=2 of a hold -> all outputs 0 and no wr_pulse.
